urv_writeback: RTL and testbench

- Final pipeline stage, directly downstream of the execute stage.
- Consumes the execute-to-writeback pipeline registers and the data-memory load/store completion signals.
- Selects and aligns the result, issues the register-file write, and stalls the pipeline while a load or store is outstanding.
- Also carries a bus-timeout watchdog and the retired-instruction counter.

---
 rtl/urv_writeback_pkg.sv | 22 ++
 rtl/urv_load_align.sv | 34 +++
 rtl/urv_writeback.sv | 135 +++++++++++++
 tb/tb_urv_writeback.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_writeback_pkg.sv
// Shared encodings for the writeback stage: load/store funct3 codes, result
// source selects and the memory-wait FSM states.
package urv_writeback_pkg;

    localparam logic [2:0] LdstB  = 3'b000;
    localparam logic [2:0] LdstH  = 3'b001;
    localparam logic [2:0] LdstW  = 3'b010;
    localparam logic [2:0] LdstBu = 3'b100;
    localparam logic [2:0] LdstHu = 3'b101;

    localparam logic [1:0] RdSourceAlu      = 2'd0;
    localparam logic [1:0] RdSourceShifter  = 2'd1;
    localparam logic [1:0] RdSourceMultiply = 2'd2;
    localparam logic [1:0] RdSourceCsr      = 2'd3;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitLoad  = 2'd1,
        StWaitStore = 2'd2
    } wb_state_e;

endpackage

// File: rtl/urv_load_align.sv
// Combinational load-data aligner: picks the byte/halfword addressed by the
// low address bits and extends it according to funct3.
module urv_load_align
    import urv_writeback_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  fun_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

        case (fun_i)
            LdstB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LdstBu:  result_o = {24'd0, byte_sel};
            LdstH:   result_o = {{16{half_sel[15]}}, half_sel};
            LdstHu:  result_o = {16'd0, half_sel};
            LdstW:   result_o = data_i;
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: result selection, register-file commit, memory-wait stall
// with bus-timeout watchdog, and the retired-instruction counter.
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        w_valid_i,
    input  logic [2:0]  w_fun_i,
    input  logic        w_load_i,
    input  logic        w_store_i,
    input  logic [4:0]  w_rd_i,
    input  logic        w_rd_write_i,
    input  logic [31:0] w_rd_value_i,
    input  logic [1:0]  w_rd_source_i,
    input  logic [31:0] w_rd_shifter_i,
    input  logic [31:0] w_rd_multiply_i,
    input  logic [31:0] w_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_stall_req_o,
    output logic        w_bus_error_o,
    output logic [63:0] csr_instrs_o
);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_valid_q, hold_valid_d;
    logic [31:0]      hold_q, hold_d;
    logic [63:0]      instrs_q, instrs_d;

    logic [31:0] aligned;
    logic [31:0] alu_result;
    logic        stall, bus_error, commit, avail, timeout;
    logic        unused_addr;

    assign unused_addr = ^w_dm_addr_i[31:2];

    urv_load_align u_load_align (
        .addr_i   (w_dm_addr_i[1:0]),
        .fun_i    (w_fun_i),
        .data_i   (dm_data_l_i),
        .result_o (aligned)
    );

    always_comb begin
        case (w_rd_source_i)
            RdSourceShifter:  alu_result = w_rd_shifter_i;
            RdSourceMultiply: alu_result = w_rd_multiply_i;
            default:          alu_result = w_rd_value_i;
        endcase
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign avail   = !w_load_i || dm_load_done_i || hold_valid_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        stall        = 1'b0;
        bus_error    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A completion already held from a stalled cycle needs no wait.
                if (w_valid_i && w_load_i && !dm_load_done_i && !hold_valid_q) begin
                    state_d = StWaitLoad;
                    stall   = 1'b1;
                end else if (w_valid_i && w_store_i && !dm_store_done_i && !hold_valid_q) begin
                    state_d = StWaitStore;
                    stall   = 1'b1;
                end
            end
            StWaitLoad, StWaitStore: begin
                if ((state_q == StWaitLoad) ? dm_load_done_i : dm_store_done_i) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = StIdle;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        commit = w_valid_i && !x_stall_i && !stall && !bus_error && avail;

        // Completion seen under an external stall is parked until it can commit.
        if (w_valid_i && x_stall_i && !hold_valid_q &&
            ((w_load_i && dm_load_done_i) || (w_store_i && dm_store_done_i))) begin
            hold_valid_d = 1'b1;
            hold_d       = aligned;
        end else if (commit) begin
            hold_valid_d = 1'b0;
        end

        instrs_d = instrs_q + 64'(commit);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            instrs_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            instrs_q     <= instrs_d;
        end
    end

    assign rf_rd_o       = w_rd_i;
    assign rf_rd_value_o = w_load_i ? (hold_valid_q ? hold_q : aligned) : alu_result;
    assign rf_rd_write_o = !rst_i && commit && w_rd_write_i && (w_rd_i != 5'd0);
    assign w_stall_req_o = !rst_i && stall;
    assign w_bus_error_o = !rst_i && bus_error;
    assign csr_instrs_o  = instrs_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Scoreboard bench for urv_writeback: directed instructions push expected
// register writes / bus errors; a negedge monitor pops and compares them.
module tb_urv_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_stall, w_valid, w_load, w_store, w_rd_write;
    logic [2:0]  w_fun;
    logic [4:0]  w_rd;
    logic [1:0]  w_src;
    logic [31:0] w_value, w_shifter, w_multiply, w_addr, dm_data;
    logic        ld_done, st_done;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value;
    logic        rf_write, stall_req, bus_error;
    logic [63:0] instrs;

    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned exp_instrs = 0;

    typedef struct {
        bit          is_err;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        ld, st, wr, exp_wr;
        logic [2:0]  fun;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] addr, data, exp_val;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    urv_writeback #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .x_stall_i       (x_stall),
        .w_valid_i       (w_valid),
        .w_fun_i         (w_fun),
        .w_load_i        (w_load),
        .w_store_i       (w_store),
        .w_rd_i          (w_rd),
        .w_rd_write_i    (w_rd_write),
        .w_rd_value_i    (w_value),
        .w_rd_source_i   (w_src),
        .w_rd_shifter_i  (w_shifter),
        .w_rd_multiply_i (w_multiply),
        .w_dm_addr_i     (w_addr),
        .dm_data_l_i     (dm_data),
        .dm_load_done_i  (ld_done),
        .dm_store_done_i (st_done),
        .rf_rd_o         (rf_rd),
        .rf_rd_value_o   (rf_value),
        .rf_rd_write_o   (rf_write),
        .w_stall_req_o   (stall_req),
        .w_bus_error_o   (bus_error),
        .csr_instrs_o    (instrs)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_valid = 0; w_load = 0; w_store = 0; w_rd_write = 0; w_fun = 3'd0;
        w_rd = 5'd0; w_src = 2'd0; w_addr = '0; dm_data = '0;
        ld_done = 0; st_done = 0; x_stall = 0;
        w_value = 32'h1111_1111; w_shifter = 32'h2222_2222; w_multiply = 32'h3333_3333;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] fun,
                         input logic [4:0] rd, input logic wr, input logic [1:0] src,
                         input logic [31:0] addr, input logic [31:0] data);
        w_valid = 1; w_load = ld; w_store = st; w_fun = fun; w_rd = rd;
        w_rd_write = wr; w_src = src; w_addr = addr; dm_data = data;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.is_err = 0; e.rd = rd; e.val = val;
        sb.push_back(e);
    endtask

    // Monitor: every rf write or bus error must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (rf_write || bus_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {62'd0, rf_write, bus_error}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_kind", {63'd0, bus_error}, {63'd0, e.is_err});
                check("event_write", {63'd0, rf_write}, {63'd0, !e.is_err});
                if (!e.is_err) begin
                    check("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
                    check("rf_value", {32'd0, rf_value}, {32'd0, e.val});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int stalls;
        exp_t e;
        //            ld st wr ew  fun     src  rd     addr           data           expected
        vecs[0]  = '{1, 0, 1, 1, 3'b000, 2'd1, 5'd5,  32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1]  = '{1, 0, 1, 1, 3'b100, 2'd1, 5'd12, 32'h0000_0101, 32'h0000_8000, 32'h0000_0080};
        vecs[2]  = '{1, 0, 1, 1, 3'b001, 2'd2, 5'd13, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001};
        vecs[3]  = '{1, 0, 1, 1, 3'b010, 2'd0, 5'd14, 32'h0000_0000, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
        vecs[4]  = '{1, 0, 1, 1, 3'b011, 2'd0, 5'd15, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{0, 0, 1, 1, 3'b000, 2'd0, 5'd9,  32'h0000_0000, 32'h0000_0000, 32'h1111_1111};
        vecs[6]  = '{0, 0, 1, 1, 3'b000, 2'd1, 5'd10, 32'h0000_0000, 32'h0000_0000, 32'h2222_2222};
        vecs[7]  = '{0, 0, 1, 1, 3'b000, 2'd2, 5'd11, 32'h0000_0000, 32'h0000_0000, 32'h3333_3333};
        vecs[8]  = '{0, 0, 1, 1, 3'b000, 2'd3, 5'd1,  32'h0000_0000, 32'h0000_0000, 32'h1111_1111};
        vecs[9]  = '{0, 0, 1, 0, 3'b000, 2'd0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{0, 1, 0, 0, 3'b010, 2'd0, 5'd3,  32'h0000_0040, 32'h0000_0000, 32'h0000_0000};

        idle();
        rst = 1;
        tick();
        tick();
        @(negedge clk);
        check("reset_write", {63'd0, rf_write}, 64'd0);
        check("reset_stall", {63'd0, stall_req}, 64'd0);
        check("reset_error", {63'd0, bus_error}, 64'd0);
        check("reset_instrs", instrs, 64'd0);
        tick();
        rst = 0;

        // Zero-latency completions and plain ALU results.
        foreach (vecs[i]) begin
            issue(vecs[i].ld, vecs[i].st, vecs[i].fun, vecs[i].rd, vecs[i].wr, vecs[i].src,
                  vecs[i].addr, vecs[i].data);
            ld_done = vecs[i].ld;
            st_done = vecs[i].st;
            if (vecs[i].exp_wr) expect_write(vecs[i].rd, vecs[i].exp_val);
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), {63'd0, stall_req}, 64'd0);
            check($sformatf("vec%0d_write", i), {63'd0, rf_write}, {63'd0, vecs[i].exp_wr});
            tick();
            idle();
            exp_instrs++;
            check($sformatf("vec%0d_instrs", i), instrs, exp_instrs);
        end

        // LHU whose data arrives three cycles late.
        issue(1, 0, 3'b101, 5'd6, 1, 2'd0, 32'h0000_0102, 32'hBEEF_1234);
        expect_write(5'd6, 32'h0000_BEEF);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ld_done = 1;
            @(negedge clk);
            if (stall_req) stalls++;
            tick();
        end
        idle();
        exp_instrs++;
        check("lhu_stall_cycles", 64'(stalls), 64'd3);
        check("lhu_instrs", instrs, exp_instrs);

        // Store that never completes: timeout after four stalled cycles.
        issue(0, 1, 3'b010, 5'd0, 0, 2'd0, 32'h0000_0080, 32'h0);
        e.is_err = 1; e.rd = '0; e.val = '0;
        sb.push_back(e);
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (i == 4) check("store_timeout_error", {63'd0, bus_error}, 64'd1);
            tick();
        end
        idle();
        check("store_stall_cycles", 64'(stalls), 64'd4);
        @(negedge clk);
        check("store_error_pulse", {63'd0, bus_error}, 64'd0);
        check("store_instrs", instrs, exp_instrs);
        tick();

        // Load completing on the very cycle the timeout would fire.
        issue(1, 0, 3'b010, 5'd7, 1, 2'd0, 32'h0000_0200, 32'hCAFE_F00D);
        expect_write(5'd7, 32'hCAFE_F00D);
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ld_done = 1;
            @(negedge clk);
            if (stall_req) stalls++;
            if (i == 4) check("race_no_error", {63'd0, bus_error}, 64'd0);
            tick();
        end
        idle();
        exp_instrs++;
        check("race_stall_cycles", 64'(stalls), 64'd4);
        check("race_instrs", instrs, exp_instrs);

        // Load completing under an external stall; later done pulse must be ignored.
        issue(1, 0, 3'b010, 5'd8, 1, 2'd0, 32'h0000_0300, 32'h1234_5678);
        x_stall = 1;
        ld_done = 1;
        expect_write(5'd8, 32'h1234_5678);
        @(negedge clk);
        check("hold_stall0", {63'd0, stall_req}, 64'd0);
        tick();
        dm_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("hold_stall1", {63'd0, stall_req}, 64'd0);
        tick();
        x_stall = 0;
        ld_done = 0;
        @(negedge clk);
        check("hold_commit", {63'd0, rf_write}, 64'd1);
        tick();
        idle();
        exp_instrs++;
        check("hold_instrs", instrs, exp_instrs);

        // Reset asserted while waiting on a load.
        issue(1, 0, 3'b000, 5'd16, 1, 2'd0, 32'h0000_0400, 32'h0);
        @(negedge clk);
        check("rst_pre_stall", {63'd0, stall_req}, 64'd1);
        tick();
        @(negedge clk);
        check("rst_wait_stall", {63'd0, stall_req}, 64'd1);
        tick();
        rst = 1;
        @(negedge clk);
        check("rst_mid_stall", {63'd0, stall_req}, 64'd0);
        check("rst_mid_write", {63'd0, rf_write}, 64'd0);
        tick();
        idle();
        rst = 0;
        exp_instrs = 0;
        @(negedge clk);
        check("post_rst_stall", {63'd0, stall_req}, 64'd0);
        check("post_rst_write", {63'd0, rf_write}, 64'd0);
        check("post_rst_error", {63'd0, bus_error}, 64'd0);
        check("post_rst_instrs", instrs, exp_instrs);
        tick();
        tick();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
